// File: rtl/alu_sweep_driver.sv
// Exhaustive sweep driver for a 4-bit, 8-function ALU: drives every legal vector,
// compares the result against the expected value and records the first failure.
module alu_sweep_driver #(
    parameter int SETTLE       = 1,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_s,
    input  logic [4:0]  alu_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] vec_cnt,
    output logic [11:0] err_cnt,
    output logic [2:0]  ff_s,
    output logic [3:0]  ff_a,
    output logic [3:0]  ff_b,
    output logic [4:0]  ff_out
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] idx;
    logic [10:0] idx_inc;
    logic [10:0] idx_nxt;
    logic [3:0]  wait_cnt;
    logic [4:0]  expected;
    logic        mismatch;
    logic        last_vec;

    // Index is {s, a, b}; division and modulo by zero are stepped over.
    always_comb begin
        idx_inc = idx + 11'd1;
        idx_nxt = idx_inc;
        if ((idx_inc[10:8] == 3'd3 || idx_inc[10:8] == 3'd4) && idx_inc[3:0] == 4'd0) begin
            idx_nxt = idx_inc + 11'd1;
        end
        last_vec = (idx == 11'h7FF);
    end

    always_comb begin
        expected = 5'd0;
        case (alu_s)
            3'd0: expected = {1'b0, alu_a};
            3'd1: expected = {1'b0, alu_a} + {1'b0, alu_b};
            3'd2: expected = {1'b0, alu_a} - {1'b0, alu_b};
            3'd3: expected = (alu_b == 4'd0) ? 5'd0 : {1'b0, alu_a / alu_b};
            3'd4: expected = (alu_b == 4'd0) ? 5'd0 : {1'b0, alu_a % alu_b};
            3'd5: expected = {alu_a, 1'b0};
            3'd6: expected = {2'b00, alu_a[3:1]};
            3'd7: expected = {4'd0, alu_a > alu_b};
            default: expected = 5'd0;
        endcase
        mismatch = (state == CHECK) && (alu_out != expected);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      state_nxt = WAIT;
            WAIT:       if (wait_cnt == 4'(SETTLE - 1)) state_nxt = CHECK;
            CHECK: begin
                if ((STOP_ON_FAIL && mismatch) || last_vec) state_nxt = DONE;
                else                                        state_nxt = DRIVE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            wait_cnt <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s    <= '0;
            vec_cnt  <= '0;
            err_cnt  <= '0;
            ff_s     <= '0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_out   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx     <= '0;
                        vec_cnt <= '0;
                        err_cnt <= '0;
                        ff_s    <= '0;
                        ff_a    <= '0;
                        ff_b    <= '0;
                        ff_out  <= '0;
                    end
                end
                DRIVE: begin
                    alu_s    <= idx[10:8];
                    alu_a    <= idx[7:4];
                    alu_b    <= idx[3:0];
                    wait_cnt <= '0;
                end
                WAIT: wait_cnt <= wait_cnt + 4'd1;
                CHECK: begin
                    vec_cnt <= vec_cnt + 12'd1;
                    idx     <= idx_nxt;
                    if (mismatch) begin
                        err_cnt <= err_cnt + 12'd1;
                        if (err_cnt == 12'd0) begin
                            ff_s   <= alu_s;
                            ff_a   <= alu_a;
                            ff_b   <= alu_b;
                            ff_out <= alu_out;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == 12'd0);

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Randomized self-checking bench for alu_sweep_driver: two instances (default and
// SETTLE=3/STOP_ON_FAIL=1) each driving a behavioural ALU with an optional planted fault.
module tb_alu_sweep_driver;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [11:0] vec;
        logic [11:0] err;
        logic [2:0]  ffs;
        logic [3:0]  ffa;
        logic [3:0]  ffb;
        logic [4:0]  ffo;
        logic [2:0]  s;
        logic [3:0]  a;
        logic [3:0]  b;
    } obs_t;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] start;

    logic [3:0]  alu_a0, alu_b0, alu_a1, alu_b1;
    logic [2:0]  alu_s0, alu_s1;
    logic [4:0]  alu_out0, alu_out1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [11:0] vec0, err0, vec1, err1;
    logic [2:0]  ffs0, ffs1;
    logic [3:0]  ffa0, ffb0, ffa1, ffb1;
    logic [4:0]  ffo0, ffo1;
    obs_t        o0, o1;

    bit fault_en [2];
    int fault_s  [2];
    int fault_a  [2];
    int fault_b  [2];
    int fault_v  [2];

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int exp_vec, exp_err, exp_lat, exp_ffs, exp_ffa, exp_ffb, exp_ffo;

    always #5 clk = ~clk;

    alu_sweep_driver dut0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]),
        .alu_a(alu_a0), .alu_b(alu_b0), .alu_s(alu_s0), .alu_out(alu_out0),
        .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vec0), .err_cnt(err0),
        .ff_s(ffs0), .ff_a(ffa0), .ff_b(ffb0), .ff_out(ffo0)
    );

    alu_sweep_driver #(.SETTLE(3), .STOP_ON_FAIL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_s(alu_s1), .alu_out(alu_out1),
        .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vec1), .err_cnt(err1),
        .ff_s(ffs1), .ff_a(ffa1), .ff_b(ffb1), .ff_out(ffo1)
    );

    assign o0 = {busy0, done0, pass0, vec0, err0, ffs0, ffa0, ffb0, ffo0, alu_s0, alu_a0, alu_b0};
    assign o1 = {busy1, done1, pass1, vec1, err1, ffs1, ffa1, ffb1, ffo1, alu_s1, alu_a1, alu_b1};

    function automatic int ref_alu(input int s, input int a, input int b);
        case (s)
            0: return a;
            1: return (a + b) % 32;
            2: return (a - b + 32) % 32;
            3: return (b == 0) ? 0 : a / b;
            4: return (b == 0) ? 0 : a % b;
            5: return (a * 2) % 32;
            6: return a / 2;
            default: return (a > b) ? 1 : 0;
        endcase
    endfunction

    // Device-side ALU: correct unless a fault is planted; undefined for divide by zero.
    function automatic logic [4:0] alu_model(input int w, input logic [2:0] s,
                                             input logic [3:0] a, input logic [3:0] b);
        if ((s == 3'd3 || s == 3'd4) && b == 4'd0) return 5'bx;
        if (fault_en[w] && int'(s) == fault_s[w] && int'(a) == fault_a[w] && int'(b) == fault_b[w])
            return 5'(fault_v[w]);
        return 5'(ref_alu(int'(s), int'(a), int'(b)));
    endfunction

    always_comb alu_out0 = alu_model(0, alu_s0, alu_a0, alu_b0);
    always_comb alu_out1 = alu_model(1, alu_s1, alu_a1, alu_b1);

    function automatic obs_t obs(input int w);
        return (w != 0) ? o1 : o0;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        cmp_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Walks the whole vector space in sweep order to predict the end-of-sweep results.
    task automatic model_sweep(input int w, input int settle, input bit stop);
        bit halted = 1'b0;
        exp_vec = 0; exp_err = 0;
        exp_ffs = 0; exp_ffa = 0; exp_ffb = 0; exp_ffo = 0;
        for (int s = 0; s < 8; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    if (halted || ((s == 3 || s == 4) && b == 0)) continue;
                    exp_vec++;
                    if (fault_en[w] && s == fault_s[w] && a == fault_a[w] && b == fault_b[w]
                        && fault_v[w] != ref_alu(s, a, b)) begin
                        if (exp_err == 0) begin
                            exp_ffs = s; exp_ffa = a; exp_ffb = b; exp_ffo = fault_v[w];
                        end
                        exp_err++;
                        if (stop) halted = 1'b1;
                    end
                end
        exp_lat = exp_vec * (settle + 2);
    endtask

    task automatic apply_stimulus(input int w);
        obs_t o;
        @(negedge clk);
        start[w] = 1'b1;
        @(posedge clk);
        #1;
        o = obs(w);
        check_output("accept_busy", o.busy, 1);
        check_output("accept_done", o.done, 0);
        check_output("accept_vec", o.vec, 0);
        check_output("accept_err", o.err, 0);
        check_output("accept_ff", {o.ffs, o.ffa, o.ffb, o.ffo}, 0);
    endtask

    // Counts edges from the accepting edge until done; start is held for 'hi' cycles
    // and pulsed once at cycle 'pulse' (negative for none).
    task automatic wait_done(input int w, input int limit, input int hi, input int pulse, output int lat);
        obs_t o;
        lat = 0;
        forever begin
            start[w] = (lat < hi) || (lat == pulse);
            if (lat >= limit) begin
                o = obs(w);
                check_output("wait_done", o.done, 1);
                break;
            end
            @(posedge clk);
            #1;
            lat++;
            o = obs(w);
            if (pulse >= 0 && lat == pulse + 1) check_output("busy_after_pulse", o.busy, 1);
            if (o.done) break;
        end
        start[w] = 1'b0;
    endtask

    task automatic check_results(input int w, input int lat, input string tag);
        obs_t o;
        o = obs(w);
        $display("[TB] %s: latency=%0d vec=%0d err=%0d", tag, lat, o.vec, o.err);
        check_output({tag, "_lat"}, lat, exp_lat);
        check_output({tag, "_vec"}, o.vec, exp_vec);
        check_output({tag, "_err"}, o.err, exp_err);
        check_output({tag, "_pass"}, o.pass, (exp_err == 0));
        check_output({tag, "_busy"}, o.busy, 0);
        check_output({tag, "_ff"}, {o.ffs, o.ffa, o.ffb, o.ffo},
                     {3'(exp_ffs), 4'(exp_ffa), 4'(exp_ffb), 5'(exp_ffo)});
    endtask

    task automatic check_zero(input int w, input string tag);
        obs_t o;
        o = obs(w);
        check_output({tag, "_flags"}, {o.busy, o.done, o.pass}, 0);
        check_output({tag, "_cnt"}, {o.vec, o.err}, 0);
        check_output({tag, "_ff"}, {o.ffs, o.ffa, o.ffb, o.ffo}, 0);
        check_output({tag, "_alu"}, {o.s, o.a, o.b}, 0);
    endtask

    initial begin
        int   lat;
        int   n;
        obs_t o;

        fault_en[0] = 1'b0; fault_en[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fault_s[i] = 0; fault_a[i] = 0; fault_b[i] = 0; fault_v[i] = 0;
        end
        rst_n = 2'b00;
        start = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        rst_n = 2'b11;
        start = 2'b00;
        @(posedge clk);
        #1;
        o = o0;
        check_output("idle_after_reset", o.busy, 0);

        // Clean sweep with a stray start pulse while busy.
        model_sweep(0, 1, 1'b0);
        apply_stimulus(0);
        wait_done(0, exp_lat + 64, 0, int'($urandom_range(10, 6000)), lat);
        check_results(0, lat, "clean");
        o = o0;
        check_output("last_vector", {o.s, o.a, o.b}, {3'd7, 4'd15, 4'd15});

        // Random planted fault; start is held high from DONE through the first cycles.
        fault_s[0] = int'($urandom_range(0, 7));
        fault_a[0] = int'($urandom_range(0, 15));
        fault_b[0] = (fault_s[0] == 3 || fault_s[0] == 4) ? int'($urandom_range(1, 15))
                                                         : int'($urandom_range(0, 15));
        fault_v[0] = ref_alu(fault_s[0], fault_a[0], fault_b[0]) ^ int'($urandom_range(1, 31));
        fault_en[0] = 1'b1;
        model_sweep(0, 1, 1'b0);
        apply_stimulus(0);
        wait_done(0, exp_lat + 64, 4, -1, lat);
        check_results(0, lat, "fault");

        // Reset in the middle of a sweep, then a fresh clean sweep.
        fault_en[0] = 1'b0;
        n = int'($urandom_range(20, 1500));
        apply_stimulus(0);
        start[0] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            o = o0;
        end while (o.vec != 12'(n) && lat < 10000);
        check_output("reach_vec", o.vec, n);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        check_zero(0, "midreset");
        rst_n[0] = 1'b1;
        @(posedge clk);
        #1;
        o = o0;
        check_output("idle_after_midreset", o.busy, 0);
        model_sweep(0, 1, 1'b0);
        apply_stimulus(0);
        wait_done(0, exp_lat + 64, 0, -1, lat);
        check_results(0, lat, "after_reset");

        // SETTLE=3, STOP_ON_FAIL=1: clean sweep, then a stuck-at-zero result.
        model_sweep(1, 3, 1'b1);
        apply_stimulus(1);
        wait_done(1, exp_lat + 64, 0, -1, lat);
        check_results(1, lat, "settle3");

        fault_s[1] = 1; fault_a[1] = 15; fault_b[1] = 15; fault_v[1] = 0;
        fault_en[1] = 1'b1;
        model_sweep(1, 3, 1'b1);
        apply_stimulus(1);
        wait_done(1, exp_lat + 64, 0, -1, lat);
        check_results(1, lat, "stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
